// File: rtl/apb_pkg.sv
// Shared register map, CTRL bit positions and decode result type for the APB timer.
package apb_pkg;
    localparam int OFF_CTRL   = 'h00;
    localparam int OFF_LOAD   = 'h04;
    localparam int OFF_VALUE  = 'h08;
    localparam int OFF_STATUS = 'h0C;
    localparam int OFF_ID     = 'h10;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_PER   = 1;
    localparam int CTRL_IRQ   = 2;
    localparam int CTRL_PS_LO = 8;
    localparam int CTRL_PS_HI = 15;

    typedef enum logic [2:0] {
        REG_CTRL, REG_LOAD, REG_VALUE, REG_STATUS, REG_ID, REG_ERR
    } reg_sel_e;
endpackage

// File: rtl/apb_timer_core.sv
// Prescaled 32-bit down-counter; flags expiry on the tick where VALUE is already 0.
module apb_timer_core
    import apb_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        en,
    input  logic        periodic,
    input  logic [7:0]  prescale,
    input  logic        load_we,
    input  logic [31:0] load_val,
    output logic [31:0] value,
    output logic        expire_pulse,
    output logic        oneshot_done
);
    logic [7:0] pcnt;
    logic       tick;

    assign tick         = en && (pcnt == prescale);
    assign expire_pulse = tick && (value == 32'd0);
    assign oneshot_done = expire_pulse && !periodic;

    // pcnt sits at 0 while disabled, so an EN rise always starts a fresh prescale period
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pcnt  <= 8'd0;
            value <= 32'd0;
        end else begin
            pcnt <= (!en || tick) ? 8'd0 : pcnt + 8'd1;
            if (load_we)
                value <= load_val;
            else if (tick) begin
                if (value != 32'd0) value <= value - 32'd1;
                else if (periodic)  value <= load_val;
            end
        end
    end
endmodule

// File: rtl/apb_timer.sv
// APB3 completer: wait-state handshake, address decode and register bank around the timer core.
module apb_timer
    import apb_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5449_4D31
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq
);
    localparam logic [3:0] WS = WAIT_STATES[3:0];

    logic [3:0]  wcnt;
    logic        access, err, we;
    reg_sel_e    sel;
    logic        en, periodic, irq_en, expired;
    logic [7:0]  prescale;
    logic [31:0] load_q, value, rdata, load_val;
    logic        load_we, expire_pulse, oneshot_done;

    assign access = PSEL && PENABLE;
    assign PREADY = access && (wcnt == WS);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)              wcnt <= 4'd0;
        else if (!PSEL || PREADY)  wcnt <= 4'd0;
        else if (access && wcnt < WS) wcnt <= wcnt + 4'd1;
    end

    always_comb begin
        sel = REG_ERR;
        if (PADDR[1:0] == 2'b00) begin
            if      (PADDR == ADDR_W'(OFF_CTRL))   sel = REG_CTRL;
            else if (PADDR == ADDR_W'(OFF_LOAD))   sel = REG_LOAD;
            else if (PADDR == ADDR_W'(OFF_VALUE))  sel = REG_VALUE;
            else if (PADDR == ADDR_W'(OFF_STATUS)) sel = REG_STATUS;
            else if (PADDR == ADDR_W'(OFF_ID))     sel = REG_ID;
        end
    end

    assign err = (sel == REG_ERR) || (PWRITE && (sel == REG_VALUE || sel == REG_ID));
    assign we  = PREADY && PWRITE && !err;

    always_comb begin
        rdata = 32'd0;
        case (sel)
            REG_CTRL:   rdata = {16'd0, prescale, 5'd0, irq_en, periodic, en};
            REG_LOAD:   rdata = load_q;
            REG_VALUE:  rdata = value;
            REG_STATUS: rdata = {31'd0, expired};
            REG_ID:     rdata = ID_VALUE;
            default:    rdata = 32'd0;
        endcase
    end

    assign PRDATA  = (PREADY && !PWRITE && !err) ? rdata : 32'd0;
    assign PSLVERR = PREADY && err;

    // a CTRL write overrides the one-shot auto-clear; a new expiry overrides W1C
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= 8'd0;
            load_q   <= 32'd0;
            expired  <= 1'b0;
        end else begin
            if (we && sel == REG_CTRL) begin
                en       <= PWDATA[CTRL_EN];
                periodic <= PWDATA[CTRL_PER];
                irq_en   <= PWDATA[CTRL_IRQ];
                prescale <= PWDATA[CTRL_PS_HI:CTRL_PS_LO];
            end else if (oneshot_done)
                en <= 1'b0;
            if (load_we) load_q <= PWDATA;
            if (expire_pulse)
                expired <= 1'b1;
            else if (we && sel == REG_STATUS && PWDATA[0])
                expired <= 1'b0;
        end
    end

    assign irq      = expired && irq_en;
    assign load_we  = we && (sel == REG_LOAD);
    assign load_val = load_we ? PWDATA : load_q;

    apb_timer_core u_core (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .en           (en),
        .periodic     (periodic),
        .prescale     (prescale),
        .load_we      (load_we),
        .load_val     (load_val),
        .value        (value),
        .expire_pulse (expire_pulse),
        .oneshot_done (oneshot_done)
    );
endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer with two wait states; expected values computed by hand.
module tb_apb_timer;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, irq;

    int n_chk = 0;
    int n_fail = 0;

    apb_timer #(.ADDR_W(12), .WAIT_STATES(2), .ID_VALUE(32'h5449_4D31)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transfer; returns at commit edge + 1.
    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int cyc);
        @(posedge ACLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            cyc++;
            if (PREADY) break;
            check("prdata_idle", PRDATA, 32'd0);
        end
        check("pready", {31'd0, PREADY}, 32'd1);
        rd = PRDATA; er = PSLVERR;
        @(posedge ACLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] r; logic e; int c;
        apb(1'b1, a, d, r, e, c);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] r; logic e; int c;
        apb(1'b0, a, 32'd0, r, e, c);
        check(tag, r, exp);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] r; logic e; int c;
        ARESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        ARESETn = 1'b1;

        // 1: ID read, ready on third access cycle
        apb(1'b0, 12'h010, 32'd0, r, e, c);
        check("id", r, 32'h5449_4D31);
        check("id_err", {31'd0, e}, 32'd0);
        check("id_wait", c, 3);

        // 2: periodic, prescale 0
        wr("load3", 12'h004, 32'd3, 1'b0);
        wr("ctrl7", 12'h000, 32'h7, 1'b0);
        @(negedge ACLK); check("p_v3", dut.value, 32'd3);
        @(negedge ACLK); check("p_v2", dut.value, 32'd2);
        @(negedge ACLK); check("p_v1", dut.value, 32'd1);
        @(negedge ACLK); check("p_v0", dut.value, 32'd0);
        check("p_irq0", {31'd0, irq}, 32'd0);
        @(negedge ACLK); check("p_reload", dut.value, 32'd3);
        check("p_irq1", {31'd0, irq}, 32'd1);
        check("p_exp", {31'd0, dut.expired}, 32'd1);
        wr("stop", 12'h000, 32'h0, 1'b0);
        wr("w1c_a", 12'h00C, 32'h1, 1'b0);
        check("clr_exp", {31'd0, dut.expired}, 32'd0);
        check("clr_irq", {31'd0, irq}, 32'd0);

        // 3: one-shot, prescale 1
        wr("load2", 12'h004, 32'd2, 1'b0);
        wr("ctrl101", 12'h000, 32'h101, 1'b0);
        repeat (6) @(negedge ACLK);
        check("os_exp5", {31'd0, dut.expired}, 32'd0);
        @(negedge ACLK);
        check("os_exp6", {31'd0, dut.expired}, 32'd1);
        check("os_irq", {31'd0, irq}, 32'd0);
        rd("os_ctrl", 12'h000, 32'h100, 1'b0);
        rd("os_value", 12'h008, 32'd0, 1'b0);

        // 4: W1C colliding with expiry, then quiet W1C
        wr("load0", 12'h004, 32'd0, 1'b0);
        wr("ctrl7b", 12'h000, 32'h7, 1'b0);
        wr("w1c_hit", 12'h00C, 32'h1, 1'b0);
        check("hit_exp", {31'd0, dut.expired}, 32'd1);
        check("hit_irq", {31'd0, irq}, 32'd1);
        wr("ctrl4", 12'h000, 32'h4, 1'b0);
        wr("w1c_q", 12'h00C, 32'h1, 1'b0);
        check("q_irq", {31'd0, irq}, 32'd0);
        rd("q_status", 12'h00C, 32'd0, 1'b0);

        // 5: error responses
        wr("load5", 12'h004, 32'd5, 1'b0);
        rd("unmapped", 12'h020, 32'd0, 1'b1);
        wr("wr_value", 12'h008, 32'hDEAD, 1'b1);
        rd("value5", 12'h008, 32'd5, 1'b0);
        rd("misalign", 12'h006, 32'd0, 1'b1);
        wr("wr_id", 12'h010, 32'h1, 1'b1);
        wr("wr_mis", 12'h005, 32'h9, 1'b1);
        rd("load_kept", 12'h004, 32'd5, 1'b0);

        // aborted transfer: PSEL dropped after one access cycle
        @(posedge ACLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h004; PWDATA = 32'h99;
        @(posedge ACLK); #1 PENABLE = 1'b1;
        @(posedge ACLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
        rd("abort_load", 12'h004, 32'd5, 1'b0);

        // 6: reset during a wait-stated LOAD write
        @(posedge ACLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h004; PWDATA = 32'h77;
        @(posedge ACLK); #1 PENABLE = 1'b1;
        @(negedge ACLK); #1 ARESETn = 1'b0;
        @(negedge ACLK);
        check("mr_pready", {31'd0, PREADY}, 32'd0);
        check("mr_value", dut.value, 32'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge ACLK);
        check("mr_pready_idle", {31'd0, PREADY}, 32'd0);
        rd("mr_load", 12'h004, 32'd0, 1'b0);
        rd("mr_ctrl", 12'h000, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- APB3 completer that sits directly downstream of the AXI-to-APB bridge and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA transfers.
- Contains a memory-mapped register bank that controls a 32-bit prescaled down-counter timer with a level interrupt.
- Returns PRDATA/PREADY/PSLVERR to the bridge.
- Supports programmable wait states and error responses for unmapped or illegal accesses.

Parameters:
- ADDR_W, 12: width of PADDR used for decode.
- WAIT_STATES, 0: number of access-phase cycles PREADY is held low (0..15).
- ID_VALUE, 32'h5449_4D31: constant returned by the ID register.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  ADDR_W  byte address.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- irq  out  1  timer interrupt, level.

Behaviour:
- Reset is ARESETn, asynchronous, active-low; the clock is ACLK. On reset:
  - All registers are 0 and the wait counter wcnt = 0.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0, irq = 0.
- Register map (word-aligned):
  - 0x00 CTRL (RW): [0] EN, [1] PERIODIC, [2] IRQ_EN, [15:8] PRESCALE; other bits read 0.
  - 0x04 LOAD (RW).
  - 0x08 VALUE (RO).
  - 0x0C STATUS (bit0 EXPIRED, write-1-to-clear).
  - 0x10 ID (RO, ID_VALUE).
- APB handshake:
  - Access phase means PSEL & PENABLE.
  - wcnt increments each access-phase cycle while wcnt < WAIT_STATES.
  - PREADY = PSEL & PENABLE & (wcnt == WAIT_STATES), combinational. With WAIT_STATES = 0, PREADY is high in the first access cycle.
  - wcnt clears on the completing cycle, and whenever PSEL is low.
- Commit: register writes and W1C take effect at the ACLK edge where PSEL & PENABLE & PREADY & PWRITE.
- PRDATA and PSLVERR are valid only while PREADY = 1; otherwise both are 0.
- PSLVERR = 1 with no state change for any of:
  - unmapped address;
  - PADDR[1:0] != 0;
  - write to VALUE or ID.
  On an error read, PRDATA = 0.
- Timer:
  - Prescaler pcnt (8 bit) counts 0..PRESCALE while EN = 1. tick = EN & (pcnt == PRESCALE); pcnt returns to 0 on tick.
  - On tick with VALUE != 0: VALUE <= VALUE - 1.
  - On tick with VALUE == 0: EXPIRED <= 1. If PERIODIC, VALUE <= LOAD; otherwise EN <= 0 (one-shot) and VALUE stays 0.
  - Period = (LOAD + 1) × (PRESCALE + 1) cycles.
- Writing LOAD also sets VALUE <= PWDATA.
- EN 0→1 via a CTRL write clears pcnt. EN = 0 freezes VALUE and holds pcnt at 0.
- irq = EXPIRED & IRQ_EN (AND of two flops).
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins (VALUE = PWDATA).
  - W1C of EXPIRED and a new expiry in the same cycle: the set wins.
  - CTRL write and one-shot auto-clear of EN in the same cycle: the CTRL write wins.
  - LOAD = 0 periodic: expires every (PRESCALE + 1) cycles.
- Protocol: PSEL dropped mid-access aborts the transfer; wcnt clears and no write occurs.
- ARESETn asserted mid-transfer: the transfer is abandoned and all state returns to reset values.

Decomposition:
- apb_pkg holds:
  - register offset localparams (CTRL/LOAD/VALUE/STATUS/ID);
  - CTRL bit-position constants;
  - an enum for the decode result (REG_CTRL, REG_LOAD, REG_VALUE, REG_STATUS, REG_ID, REG_ERR).
- One sub-module, apb_timer_core: prescaler plus down-counter.
  - Inputs: en, periodic, prescale, load_we, load_val.
  - Outputs: value, expire_pulse, oneshot_done.
- The top level holds the APB front-end, wait-state counter, decode and register bank.

Test Plan:
1. Reset then read ID at 0x10 → PRDATA = 32'h5449_4D31, PSLVERR = 0; with WAIT_STATES = 2, PREADY rises on the 3rd access cycle.
2. Write LOAD = 3, CTRL = 0x0000_0007 (EN, PERIODIC, IRQ_EN, PRESCALE = 0) → VALUE reads 2,1,0 on successive cycles; EXPIRED and irq = 1 at the 4th edge after the CTRL commit; VALUE reloads to 3.
3. One-shot: LOAD = 2, CTRL = 0x0000_0101 (PRESCALE = 1) → EXPIRED after 6 cycles; CTRL.EN reads 0; VALUE holds 0; irq stays 0.
4. Write 1 to STATUS on the same cycle as an expiry → EXPIRED stays 1; a W1C on a quiet cycle → EXPIRED = 0 and irq = 0.
5. Read 0x20, write VALUE, read 0x06 → PSLVERR = 1, PRDATA = 0, no register change.
6. Assert ARESETn low during a wait-stated LOAD write → after release, LOAD = 0, VALUE = 0, PREADY = 0.
